// File: rtl/bus_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter with packet locking and a registered
// output slice; each output beat carries the index of its source requester.
module bus_rr_arbiter #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int IDW   = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N-1:0]         valid_i,
   output logic [N-1:0]         ready_o,
   input  logic [N*WIDTH-1:0]   data_i,
   input  logic [N-1:0]         last_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [WIDTH-1:0]     data_o,
   output logic                 last_o,
   output logic [IDW-1:0]       grant_id_o
);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;

   logic             slot_free;
   logic             found;
   logic             xfer;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   sel;
   logic [IDW-1:0]   sel_next;
   int unsigned      idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr_q) + i) % N;
         if (!found && valid_i[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end

      slot_free = ~valid_q | ready_i;
      sel       = (state_q == ST_LOCKED) ? owner_q : winner;
      sel_next  = (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;

      // Gated by rstn so no requester sees an accept while the beat would be lost.
      ready_o = '0;
      if (rstn && slot_free && (state_q == ST_LOCKED || found)) begin
         ready_o[sel] = 1'b1;
      end
      xfer = valid_i[sel] & ready_o[sel];

      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      if (xfer) begin
         if (last_i[sel]) begin
            state_d = ST_IDLE;
            ptr_d   = sel_next;
         end else begin
            state_d = ST_LOCKED;
            owner_d = sel;
         end
      end

      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      id_d    = id_q;
      if (slot_free) begin
         valid_d = xfer;
         if (xfer) begin
            data_d = data_i[int'(sel)*WIDTH +: WIDTH];
            last_d = last_i[sel];
            id_d   = sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         id_q    <= id_d;
      end
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign last_o     = last_q;
   assign grant_id_o = id_q;

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter that lets N master channels share one valid/ready slave channel, with packet locking and a registered output stage. It sits in front of the shared slave port and owns the output register slice for the merged stream. Requesters are sequenced packet by packet: once a requester wins, it keeps the grant until its `last` beat is accepted. Every output beat is tagged with the source index.

## Interface
- `WIDTH`, default 32: data width per beat.
- `N`, default 4: number of requesters. Must be at least 2.
- `IDW`, default `$clog2(N)`: width of the grant index.

- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous reset, active-low.
- `valid_i`  in  N  per-requester beat valid; bit k belongs to requester k.
- `ready_o`  out  N  per-requester beat accept.
- `data_i`  in  N*WIDTH  requester k data is `data_i[k*WIDTH +: WIDTH]`.
- `last_i`  in  N  per-requester final beat of packet.
- `valid_o`  out  1  beat valid to slave; registered.
- `ready_i`  in  1  slave accept.
- `data_o`  out  WIDTH  beat data to slave; registered.
- `last_o`  out  1  final beat of packet; registered.
- `grant_id_o`  out  IDW  source requester of the current output beat; registered.

## Operation
- **Output slot**
  - `slot_free = ~valid_o | ready_i`.
  - When `slot_free` is high and a beat is accepted, the register loads {data, last, id} and `valid_o` is set to 1.
  - When `slot_free` is high and no beat is accepted, `valid_o` is cleared to 0 and data/last/id hold.
  - When `slot_free` is low, all outputs hold.
- **Beat transfer:** a beat from requester k transfers in a cycle where `valid_i[k] & ready_o[k]`. At most one bit of `ready_o` is high in any cycle.
- **State IDLE**
  - Winner = first k with `valid_i[k]=1`, searching `ptr, ptr+1, … N-1, 0, … ptr-1`.
  - `ready_o[winner] = slot_free`; all other `ready_o` bits are 0.
  - On transfer with `last_i[winner]=1`: stay in IDLE and set `ptr = winner+1 mod N`.
  - On transfer with `last_i[winner]=0`: go to LOCKED with `owner = winner`.
  - With no transfer, `ptr` is unchanged.
- **State LOCKED**
  - `ready_o[owner] = slot_free`; all other bits are 0.
  - Other requesters are never granted, even while the owner has `valid_i` low. The bubble propagates as `valid_o=0`.
  - When the owner's beat with `last_i=1` transfers: go to IDLE and set `ptr = owner+1 mod N`.
- **ready_o path:** `ready_o` is combinational from `valid_i`, `ptr`, state and `slot_free`. Ready is allowed to depend on valid. No requester's valid may depend on its ready.
- **Pointer wrap:** `ptr` wraps from N-1 to 0.
- **Fairness:** a requester holding `valid_i` waits at most N-1 packets.
- **Reset**
  - Values: `valid_o=0`, `data_o=0`, `last_o=0`, `grant_id_o=0`, `ready_o=0` (slot free, no valid), state IDLE, `ptr=0`, `owner=0`.
  - Reset mid-packet drops the packet and the held output beat. After release, arbitration restarts from requester 0.

## Timing
- Latency is 1 cycle: a beat transferred at edge t appears on `valid_o`/`data_o` after edge t.
- Throughput is one beat per cycle while `ready_i=1`, including back-to-back packets from different requesters. There is no dead cycle at a grant change.
- When `ready_i` is low and `valid_o` is high, all `ready_o` bits are 0 in the same cycle. `data_o`, `last_o` and `grant_id_o` stay stable until accepted.
- When `valid_o=1` and `ready_i=1` in the same cycle, the next beat loads in that cycle (simultaneous drain and fill).
- A single-beat packet (`last_i=1` on the first beat) never enters LOCKED.

## Test plan
- **Reset and single beat:** hold `rstn` low with random `valid_i`.
  - During reset: all outputs are 0.
  - After release, `valid_i=4'b0100`, `data_i[95:64]=32'hA5A5_0001`, `last_i[2]=1`, `ready_i=1`: `ready_o=4'b0100`; next cycle `valid_o=1`, `data_o=32'hA5A5_0001`, `grant_id_o=2`, `last_o=1`.
- **Round-robin order:** all four requesters continuously send 1-beat packets, `ready_i=1`. Expected `grant_id_o` sequence is 0,1,2,3,0,1… with no idle cycle.
- **Packet lock:**
  - Stimulus: requester 1 sends a 3-beat packet and deasserts `valid_i[1]` for 2 cycles after beat 1. Requester 3 is valid throughout.
  - Response: `ready_o[3]=0` until requester 1's `last` transfers, and `valid_o=0` during the gap. Requester 3 is granted in the cycle after `last`.
- **Backpressure:**
  - Stimulus: `ready_i=0` for 5 cycles while a beat with `data_o=32'h0000_00FF` is held.
  - Response: `data_o`, `last_o` and `grant_id_o` are stable, and `ready_o=0`. When `ready_i` returns to 1, the same cycle shows `ready_o[owner]=1`.
- **Wrap:**
  - Stimulus: `ptr=3`, `valid_i=4'b1001`.
  - Response: the winner is 3, then 0 on the next packet.
- **Reset mid-packet:** assert `rstn=0` after beat 2 of a 4-beat packet from requester 2. After release: IDLE, `ptr=0`, and requester 0 wins if `valid_i=4'b0101`.
